// File: rtl/if_pkg.sv
// Shared types and width helpers for the IF sample packer and its PPS front end.
package if_pkg;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int unsigned WARMUP_DEFAULT = 32'h0F51_6E80;

    function automatic int sample_width(input int nch, input int bps);
        return nch * bps;
    endfunction

    function automatic int samples_per_word(input int dw, input int sw);
        return dw / sw;
    endfunction

    // A slot index needs at least one bit even when a word holds a single sample.
    function automatic int slot_idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/if_pps_sync.sv
// Two-flop synchroniser for the asynchronous PPS input followed by a one-clock
// rising-edge pulse.
module if_pps_sync (
    input  logic clk,
    input  logic reset,
    input  logic pps,
    output logic pps_rise
);

    logic sync_p0;
    logic sync_p1;
    logic edge_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
        end else begin
            sync_p0 <= pps;
            sync_p1 <= sync_p0;
            edge_p2 <= sync_p1;
        end
    end

    assign pps_rise = sync_p1 & ~edge_p2;

endmodule

// File: rtl/if_sample_packer.sv
// Packs NCH-channel sign/magnitude IF samples into DW-bit words after a warm-up
// delay, with valid/ready output, drop accounting and PPS word tagging.
module if_sample_packer
    import if_pkg::*;
#(
    parameter int          NCH           = 4,
    parameter int          BPS           = 2,
    parameter int          DW            = 16,
    parameter int unsigned WARMUP_CYCLES = WARMUP_DEFAULT,
    localparam int         PSW           = slot_idx_width(samples_per_word(DW, sample_width(NCH, BPS)))
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*BPS-1:0]   if_data,
    input  logic                 enable,
    input  logic                 pps,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_pps,
    output logic [PSW-1:0]       out_pps_slot,
    output logic                 started,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);

    localparam int             SW        = sample_width(NCH, BPS);
    localparam int             K         = samples_per_word(DW, SW);
    localparam bit             WARM_NONE = (WARMUP_CYCLES == 0);
    localparam logic [27:0]    WARM_LAST = WARM_NONE ? 28'd0 : 28'(WARMUP_CYCLES - 1);
    localparam logic [PSW-1:0] IDX_LAST  = PSW'(K - 1);

    generate
        if (DW % SW != 0) begin : g_bad_width
            $error("if_sample_packer: DW must be a multiple of NCH*BPS");
        end
    endgenerate

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t            state;
    state_t            state_nxt;
    logic [27:0]       warm_cnt;

    logic [SW-1:0]     in_data_p0;
    logic              vld_p0;

    logic [DW-1:0]     word_acc;
    logic [DW-1:0]     word_full;
    logic [PSW-1:0]    idx;
    logic              capture;
    logic              word_done;
    logic              word_load;
    logic              word_drop;

    logic              pps_rise;
    logic              pps_pending;
    logic              pps_now;
    logic              tag_pps;
    logic [PSW-1:0]    tag_slot;
    logic              word_pps;
    logic [PSW-1:0]    word_slot;

    if_pps_sync u_pps_sync (
        .clk      (clk),
        .reset    (reset),
        .pps      (pps),
        .pps_rise (pps_rise)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WARMUP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WARMUP: if (WARM_NONE || warm_cnt == WARM_LAST) state_nxt = RUN;
            RUN:    state_nxt = RUN;
        endcase
    end

    // started lags RUN by one clock so the first capture follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= 28'd0;
            started  <= 1'b0;
        end else begin
            if (state == WARMUP) warm_cnt <= warm_cnt + 28'd1;
            if (state == RUN)    started  <= 1'b1;
        end
    end

    // ---- stage p0: input register, enable aligned alongside ----
    always_ff @(posedge clk) begin
        in_data_p0 <= if_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= enable;
        end
    end

    // ---- stage p1: slot packing and output offer ----
    assign capture   = started & vld_p0;
    assign word_done = capture && (idx == IDX_LAST);
    assign word_load = word_done && (!out_valid || out_ready);
    assign word_drop = word_done && out_valid && !out_ready;

    assign pps_now   = pps_pending | pps_rise;
    assign word_pps  = tag_pps | pps_now;
    assign word_slot = tag_pps ? tag_slot : idx;

    always_comb begin
        word_full = word_acc;
        word_full[(K-1)*SW +: SW] = in_data_p0;
    end

    always_ff @(posedge clk) begin
        if (capture) word_acc[int'(idx)*SW +: SW] <= in_data_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            pps_pending <= 1'b0;
            tag_pps     <= 1'b0;
            tag_slot    <= '0;
        end else begin
            if (!vld_p0) begin
                idx <= '0;
            end else if (capture) begin
                idx <= word_done ? '0 : idx + 1'b1;
            end

            if (capture) begin
                pps_pending <= 1'b0;
            end else if (pps_rise) begin
                pps_pending <= 1'b1;
            end

            // A tag belongs to the word being built; it dies with a discarded partial.
            if (!vld_p0 || word_done) begin
                tag_pps <= 1'b0;
            end else if (capture && pps_now && !tag_pps) begin
                tag_pps  <= 1'b1;
                tag_slot <= idx;
            end
        end
    end

    // ---- stage p2: output holding register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_pps      <= 1'b0;
            out_pps_slot <= '0;
            overflow     <= 1'b0;
            drop_cnt     <= 16'd0;
        end else begin
            if (word_load) begin
                out_data     <= word_full;
                out_valid    <= 1'b1;
                out_pps      <= word_pps;
                out_pps_slot <= word_slot;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_pps   <= 1'b0;
            end

            if (word_drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
        end
    end

endmodule

// File: tb/tb_if_sample_packer.sv
// Directed bench for if_sample_packer: a K=2 instance with a short warm-up and a
// K=1 instance that starts immediately, sharing clock, reset and inputs.
module tb_if_sample_packer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;
    logic        pps;
    logic [7:0]  if_data;
    logic        out_ready;
    logic        k_ready;

    logic [15:0] o_data;
    logic        o_valid;
    logic        o_pps;
    logic [0:0]  o_slot;
    logic        o_started;
    logic        o_ovf;
    logic [15:0] o_drop;

    logic [7:0]  k_data;
    logic        k_valid;
    logic        k_pps;
    logic [0:0]  k_slot;
    logic        k_started;
    logic        k_ovf;
    logic [15:0] k_drop;

    if_sample_packer #(.NCH(4), .BPS(2), .DW(16), .WARMUP_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_data      (if_data),
        .enable       (enable),
        .pps          (pps),
        .out_data     (o_data),
        .out_valid    (o_valid),
        .out_ready    (out_ready),
        .out_pps      (o_pps),
        .out_pps_slot (o_slot),
        .started      (o_started),
        .overflow     (o_ovf),
        .drop_cnt     (o_drop)
    );

    if_sample_packer #(.NCH(4), .BPS(2), .DW(8), .WARMUP_CYCLES(0)) dut_k1 (
        .clk          (clk),
        .reset        (reset),
        .if_data      (if_data),
        .enable       (enable),
        .pps          (pps),
        .out_data     (k_data),
        .out_valid    (k_valid),
        .out_ready    (k_ready),
        .out_pps      (k_pps),
        .out_pps_slot (k_slot),
        .started      (k_started),
        .overflow     (k_ovf),
        .drop_cnt     (k_drop)
    );

    typedef struct {
        logic [7:0]  s0;
        logic [7:0]  s1;
        logic [15:0] word;
    } pack_vec_t;

    pack_vec_t  vecs[4];
    logic [7:0] kv[10];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        if_data = d;
        enable  = 1'b1;
        cyc();
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic warmup_check();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) cyc();
        chk("rst_valid",   o_valid,   0);
        chk("rst_data",    o_data,    0);
        chk("rst_started", o_started, 0);
        chk("rst_ovf",     o_ovf,     0);
        chk("rst_drop",    o_drop,    0);
        chk("rst_pps",     o_pps,     0);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("warm_started_%0d", k), o_started, 0);
            chk($sformatf("warm_valid_%0d", k), o_valid, 0);
            if (k == 1) chk("k1_started_1", k_started, 0);
            if (k == 2) chk("k1_started_2", k_started, 1);
        end
        cyc();
        chk("warm_started_11", o_started, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{s0: 8'hA1, s1: 8'h5C, word: 16'h5CA1};
        vecs[1] = '{s0: 8'h00, s1: 8'hFF, word: 16'hFF00};
        vecs[2] = '{s0: 8'h3C, s1: 8'hC3, word: 16'hC33C};
        vecs[3] = '{s0: 8'h7E, s1: 8'h81, word: 16'h817E};
        for (int i = 0; i < 10; i++) kv[i] = 8'(i * 37 + 5);

        reset     = 1'b1;
        enable    = 1'b0;
        pps       = 1'b0;
        if_data   = 8'h00;
        out_ready = 1'b1;
        k_ready   = 1'b1;

        warmup_check();

        // table-driven packing
        idle(2);
        for (int i = 0; i < 4; i++) begin
            idle(2);
            push(vecs[i].s0);
            push(vecs[i].s1);
            idle(1);
            chk($sformatf("pack_valid_%0d", i), o_valid, 1);
            chk($sformatf("pack_data_%0d", i), o_data, vecs[i].word);
            chk($sformatf("pack_pps_%0d", i), o_pps, 0);
            idle(1);
            chk($sformatf("pack_drain_%0d", i), o_valid, 0);
        end

        // backpressure: one held, two dropped
        chk("bp_ovf_before", o_ovf, 0);
        out_ready = 1'b0;
        idle(2);
        push(8'h11); push(8'h22);
        push(8'h33); push(8'h44);
        push(8'h55); push(8'h66);
        idle(2);
        chk("bp_valid", o_valid, 1);
        chk("bp_held",  o_data,  16'h2211);
        chk("bp_ovf",   o_ovf,   1);
        chk("bp_drop",  o_drop,  2);
        out_ready = 1'b1;
        chk("bp_release_data", o_data, 16'h2211);
        cyc();
        chk("bp_release_valid", o_valid, 0);

        // PPS aligned to the second sample of a word
        idle(2);
        pps = 1'b1;
        push(8'h01);
        push(8'h02);
        pps = 1'b0;
        push(8'h03);
        chk("ppsA_valid", o_valid, 1);
        chk("ppsA_data",  o_data,  16'h0201);
        chk("ppsA_tag",   o_pps,   1);
        chk("ppsA_slot",  o_slot,  1);
        push(8'h04);
        chk("ppsA_gap", o_valid, 0);
        idle(1);
        chk("ppsA_next_data", o_data, 16'h0403);
        chk("ppsA_next_tag",  o_pps,  0);

        // two edges inside one clock while idle -> one pending tag
        idle(2);
        pps = 1'b1;
        cyc();
        pps = 1'b0;
        #1;
        pps = 1'b1;
        cyc();
        pps = 1'b0;
        idle(3);
        push(8'h0A);
        push(8'h0B);
        push(8'h0C);
        chk("ppsB_data", o_data, 16'h0B0A);
        chk("ppsB_tag",  o_pps,  1);
        chk("ppsB_slot", o_slot, 0);
        push(8'h0D);
        idle(1);
        chk("ppsB_next_data", o_data, 16'h0D0C);
        chk("ppsB_next_tag",  o_pps,  0);

        // enable drop mid-word discards the partial
        idle(2);
        push(8'hE0);
        push(8'hE1);
        push(8'hE2);
        chk("endrop_first", o_data, 16'hE1E0);
        idle(2);
        chk("endrop_idle", o_valid, 0);
        push(8'hF0);
        push(8'hF1);
        idle(1);
        chk("endrop_valid", o_valid, 1);
        chk("endrop_data",  o_data,  16'hF1F0);

        // reset mid-RUN with a held word and a partial
        idle(2);
        out_ready = 1'b0;
        push(8'hAA);
        push(8'hBB);
        push(8'hCC);
        push(8'hDD);
        chk("mid_held", o_valid, 1);
        chk("mid_drop_before", o_drop, 2);
        reset = 1'b1;
        cyc();
        chk("mid_valid",   o_valid,   0);
        chk("mid_drop",    o_drop,    0);
        chk("mid_started", o_started, 0);
        chk("mid_ovf",     o_ovf,     0);
        out_ready = 1'b1;
        warmup_check();
        idle(2);
        push(8'h9A);
        push(8'h5B);
        idle(1);
        chk("restart_data", o_data, 16'h5B9A);

        // K=1: back-to-back words with simultaneous accept and load
        idle(3);
        for (int i = 0; i < 10; i++) begin
            push(kv[i]);
            if (i >= 1) begin
                chk($sformatf("k1_valid_%0d", i), k_valid, 1);
                chk($sformatf("k1_data_%0d", i), k_data, kv[i-1]);
            end
        end
        idle(1);
        chk("k1_last_data", k_data, kv[9]);
        idle(1);
        chk("k1_end_valid", k_valid, 0);
        chk("k1_drop", k_drop, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_sample_packer.md
# if_sample_packer

Parametrised packer for the multi-channel IF front-end. It registers NCH sign/magnitude samples every clock after a programmable warm-up delay and packs K consecutive samples into DW-bit words for the slave-FIFO path to the USB bridge. Output uses a valid/ready handshake. It counts words dropped when the downstream FIFO stalls, and marks the word that holds the first sample after each PPS edge. It sits between the IF input pins and the dual-clock slave FIFO, and generalises the current fixed 4-channel/8-bit capture.

## Interface
- NCH, 4: number of IF channels
- BPS, 2: bits per channel sample ({sign, magn}, magn in LSB)
- DW, 16: output word width; DW % (NCH*BPS) == 0 required (elaboration error otherwise)
- WARMUP_CYCLES, 28'hF516E80: clocks from reset release to capture enable; 0 means start immediately
- clk  in  1  sample clock (IF clock); all logic on rising edge
- reset  in  1  synchronous, active-high
- if_data  in  NCH*BPS  channel c occupies bits [c*BPS +: BPS]
- enable  in  1  capture enable (bridge-ready level, already in clk domain)
- pps  in  1  asynchronous pulse-per-second
- out_data  out  DW  packed word, reset 0
- out_valid  out  1  word available, reset 0
- out_ready  in  1  downstream accepts (e.g. ~AlmostFull)
- out_pps  out  1  word contains first sample after a PPS edge, reset 0
- out_pps_slot  out  $clog2(K) (min 1)  slot index of that sample, reset 0
- started  out  1  warm-up complete (drives USB start), reset 0
- overflow  out  1  sticky: a word was dropped, reset 0; cleared only by reset
- drop_cnt  out  16  dropped-word count, saturates at 16'hFFFF, reset 0

## Operation
- SW = NCH*BPS; K = DW/SW samples per word.
- States:
  - WARMUP: a 28-bit counter runs to WARMUP_CYCLES-1, then moves to RUN and sets started=1. started stays 1 until reset.
  - RUN: captures samples while enable=1.
  - reset from any state returns to WARMUP with all registers cleared.
- Input stage: if_data is registered every clock into in_reg, unconditionally.
- Capture:
  - In RUN with enable_d=1 (enable delayed one clock, aligned to in_reg), in_reg is written into slot[idx] and idx increments.
  - Slot 0 maps to LSBs: slot s = bits [s*SW +: SW].
- Word completion: when slot K-1 is written, the full word plus its PPS tag is offered to the output register in the same edge, and idx wraps to 0.
- Output register:
  - Loaded if out_valid=0 or (out_valid & out_ready) that cycle.
  - Otherwise the completed word is dropped: overflow is set and drop_cnt increments.
  - The held word is never overwritten.
- Accept: out_valid & out_ready with no new load clears out_valid. Simultaneous accept and load keeps out_valid=1 with the new word.
- PPS:
  - pps passes through a 2-flop synchroniser, then a rising-edge detect.
  - An edge sets pending. The next captured sample clears pending and records the tag (pps=1, slot=idx) for the word being built.
  - A second edge before capture is absorbed.
  - If the tagged word is dropped, the tag is lost.
- enable falling with a partial word: idx is reset to 0 and partial slots are discarded. A held output word still drains.

## Timing
- Sample presented before edge t enters in_reg at t. It is written into its slot at t+1 if enable was high before edge t.
- The last slot's word appears on out_data/out_valid after edge t+1. Latency is 2 clocks from if_data to out_valid for slot K-1.
- Sustained rate: one word per K clocks. With K=1, one word per clock and full throughput when out_ready=1.
- PPS to tag: edge on pps before clock e is detected at e+2 (sync) / e+3 (edge reg). The first capture at or after that edge carries the tag.
- started rises WARMUP_CYCLES+1 clocks after reset falls. The first capture is possible one clock later.

## Structure
- Shared package if_pkg:
  - SW/K derivation functions
  - state enum {WARMUP, RUN}
  - WARMUP default constant
- Sub-module if_pps_sync: 2-flop synchroniser plus rising-edge pulse. The rest stays in one module.

## Test plan
- Warm-up: WARMUP_CYCLES=10, enable=1 → started=0 until the 11th clock after reset release; no out_valid before then.
- Packing: NCH=4, BPS=2, DW=16, out_ready=1, if_data=8'hA1 then 8'h5C → out_data=16'h5CA1, out_valid for 1 cycle, 2 clocks after 8'h5C.
- Backpressure: out_ready=0 for 3 words → first word held, 2 dropped, overflow=1, drop_cnt=2. Release → held word accepted unchanged.
- Simultaneous accept and load with K=1 and continuous ready → out_valid stays high, every input appears in order, drop_cnt=0.
- PPS: edge aligned to the second sample of a word → exactly one word with out_pps=1, out_pps_slot=1. Two edges within 1 clock → single tag.
- Reset mid-RUN with a partial word and held output → out_valid=0, drop_cnt=0, started=0 the next cycle, warm-up restarts. Enable drop mid-word → partial discarded, next word starts at slot 0.
